// File: rtl/cpu_bus_router.sv
// CPU bus-cycle controller: decodes each 68020/030 cycle to block RAM, SDRAM or bus error
// and owns every strobe and acknowledge. All outputs are registered.
module cpu_bus_router #(
   parameter int unsigned BRAM_ADDR_BITS = 19,
   parameter logic [31:0] SDRAM_TOP      = 32'h03FF_FFFF,
   parameter int unsigned BRAM_WAIT      = 1,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic        CLK_114,
   input  logic        RESET_N,
   input  logic        AS_N,
   input  logic [31:0] ADR_OUT,
   input  logic        RWn,
   input  logic [1:0]  SIZE,
   input  logic [31:0] DATA_OUT,
   output logic [31:0] DATA_IN,
   output logic [1:0]  DSACKn,
   output logic        BERRn,
   output logic        bram_en,
   output logic [3:0]  bram_we,
   output logic [31:0] bram_adr,
   output logic [31:0] bram_wdata,
   input  logic [31:0] bram_rdata,
   output logic        sd_req,
   output logic        sd_we,
   output logic [31:0] sd_adr,
   output logic [3:0]  sd_be,
   output logic [31:0] sd_wdata,
   input  logic [31:0] sd_rdata,
   input  logic        sd_ack
);

   typedef enum logic [2:0] {IDLE, BRAM, SDRAM, ACK, BERR, DRAIN} state_t;

   localparam logic [32:0] BRAM_LIMIT = 33'd1 << BRAM_ADDR_BITS;
   localparam logic [15:0] WAIT_DONE  = 16'(BRAM_WAIT + 1);
   localparam logic [15:0] TO_LIM     = 16'(TIMEOUT);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        abort_q, abort_d;
   logic        rd_q, rd_d;
   logic [31:0] data_in_q, data_in_d;
   logic [1:0]  dsack_q, dsack_d;
   logic        berr_n_q, berr_n_d;
   logic        bram_en_q, bram_en_d;
   logic [3:0]  bram_we_q, bram_we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        sd_req_q, sd_req_d;
   logic        sd_we_q, sd_we_d;
   logic [3:0]  sd_be_q, sd_be_d;

   logic [2:0]  off, len, last;
   logic [3:0]  mask;
   logic        in_bram, in_sd;

   // Lanes off..min(off+len-1,3); lane 0 (D31:24) is mask bit 3.
   always_comb begin
      off     = {1'b0, ADR_OUT[1:0]};
      len     = (SIZE == 2'b00) ? 3'd4 : {1'b0, SIZE};
      last    = off + len - 3'd1;
      mask    = {off == 3'd0,
                 (off <= 3'd1) && (last >= 3'd1),
                 (off <= 3'd2) && (last >= 3'd2),
                 last >= 3'd3};
      in_bram = {1'b0, ADR_OUT} < BRAM_LIMIT;
      in_sd   = !in_bram && (ADR_OUT <= SDRAM_TOP);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      abort_d   = abort_q;
      rd_d      = rd_q;
      data_in_d = data_in_q;
      dsack_d   = 2'b11;
      berr_n_d  = 1'b1;
      bram_en_d = 1'b0;
      bram_we_d = bram_we_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      sd_req_d  = 1'b0;
      sd_we_d   = sd_we_q;
      sd_be_d   = sd_be_q;
      case (state_q)
         IDLE: begin
            if (!AS_N) begin
               adr_d     = ADR_OUT;
               wdata_d   = DATA_OUT;
               rd_d      = RWn;
               cnt_d     = '0;
               abort_d   = 1'b0;
               bram_we_d = '0;
               sd_be_d   = '0;
               sd_we_d   = 1'b0;
               if (in_bram) begin
                  state_d = BRAM;
                  if (!RWn) bram_we_d = mask;
               end else if (in_sd) begin
                  state_d = SDRAM;
                  sd_be_d = mask;
                  sd_we_d = !RWn;
               end else begin
                  state_d = BERR;
               end
            end
         end
         BRAM: begin
            // The access always runs to completion; an abort only suppresses the acknowledge.
            bram_en_d = (cnt_q == '0);
            cnt_d     = cnt_q + 16'd1;
            if (AS_N) abort_d = 1'b1;
            if (cnt_q == WAIT_DONE) begin
               if (abort_q || AS_N) begin
                  state_d = IDLE;
               end else begin
                  state_d = ACK;
                  dsack_d = 2'b00;
                  if (rd_q) data_in_d = bram_rdata;
               end
            end
         end
         SDRAM: begin
            sd_req_d = 1'b1;
            if (cnt_q != TO_LIM) cnt_d = cnt_q + 16'd1;
            if (sd_ack) begin
               if (AS_N) begin
                  state_d = IDLE;
               end else begin
                  state_d = ACK;
                  if (rd_q) data_in_d = sd_rdata;
               end
            end else if (cnt_q == TO_LIM) begin
               state_d = AS_N ? IDLE : BERR;
            end else if (AS_N) begin
               state_d = DRAIN;
            end
         end
         ACK: begin
            dsack_d = 2'b00;
            if (AS_N) state_d = IDLE;
         end
         BERR: begin
            berr_n_d = 1'b0;
            if (AS_N) state_d = IDLE;
         end
         DRAIN: begin
            sd_req_d = 1'b1;
            if (cnt_q != TO_LIM) cnt_d = cnt_q + 16'd1;
            if (sd_ack || (cnt_q == TO_LIM)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_114) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         abort_q   <= 1'b0;
         rd_q      <= 1'b0;
         data_in_q <= '0;
         dsack_q   <= 2'b11;
         berr_n_q  <= 1'b1;
         bram_en_q <= 1'b0;
         bram_we_q <= '0;
         adr_q     <= '0;
         wdata_q   <= '0;
         sd_req_q  <= 1'b0;
         sd_we_q   <= 1'b0;
         sd_be_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         abort_q   <= abort_d;
         rd_q      <= rd_d;
         data_in_q <= data_in_d;
         dsack_q   <= dsack_d;
         berr_n_q  <= berr_n_d;
         bram_en_q <= bram_en_d;
         bram_we_q <= bram_we_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         sd_req_q  <= sd_req_d;
         sd_we_q   <= sd_we_d;
         sd_be_q   <= sd_be_d;
      end
   end

   assign DATA_IN    = data_in_q;
   assign DSACKn     = dsack_q;
   assign BERRn      = berr_n_q;
   assign bram_en    = bram_en_q;
   assign bram_we    = bram_we_q;
   assign bram_adr   = adr_q;
   assign bram_wdata = wdata_q;
   assign sd_req     = sd_req_q;
   assign sd_we      = sd_we_q;
   assign sd_adr     = adr_q;
   assign sd_be      = sd_be_q;
   assign sd_wdata   = wdata_q;

endmodule

// File: tb/tb_cpu_bus_router.sv
// Directed bench for cpu_bus_router; "eN" below means the Nth clock edge after AS_N low is sampled.
module tb_cpu_bus_router;

   logic        CLK_114 = 1'b0;
   logic        RESET_N = 1'b0;
   logic        AS_N = 1'b1;
   logic [31:0] ADR_OUT = '0;
   logic        RWn = 1'b1;
   logic [1:0]  SIZE = 2'b00;
   logic [31:0] DATA_OUT = '0;
   logic [31:0] DATA_IN;
   logic [1:0]  DSACKn;
   logic        BERRn;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [31:0] bram_adr;
   logic [31:0] bram_wdata;
   logic [31:0] bram_rdata = '0;
   logic        sd_req;
   logic        sd_we;
   logic [31:0] sd_adr;
   logic [3:0]  sd_be;
   logic [31:0] sd_wdata;
   logic [31:0] sd_rdata = '0;
   logic        sd_ack = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   cpu_bus_router #(
      .BRAM_ADDR_BITS(19),
      .SDRAM_TOP(32'h03FF_FFFF),
      .BRAM_WAIT(1),
      .TIMEOUT(255)
   ) dut (
      .CLK_114(CLK_114), .RESET_N(RESET_N), .AS_N(AS_N), .ADR_OUT(ADR_OUT),
      .RWn(RWn), .SIZE(SIZE), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN),
      .DSACKn(DSACKn), .BERRn(BERRn), .bram_en(bram_en), .bram_we(bram_we),
      .bram_adr(bram_adr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
      .sd_req(sd_req), .sd_we(sd_we), .sd_adr(sd_adr), .sd_be(sd_be),
      .sd_wdata(sd_wdata), .sd_rdata(sd_rdata), .sd_ack(sd_ack)
   );

   always #5 CLK_114 = ~CLK_114;

   task automatic tick();
      @(posedge CLK_114);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Long read from block RAM; rdata is valid only in the cycle before e3.
   task automatic bram_read(input string tag, input logic [31:0] a, input logic [31:0] d);
      AS_N = 1'b0; ADR_OUT = a; RWn = 1'b1; SIZE = 2'b00; bram_rdata = '0;
      tick();                                   // e0
      chk({tag, "_en_e0"}, 32'(bram_en), 32'h0);
      tick();                                   // e1
      chk({tag, "_en_e1"}, 32'(bram_en), 32'h1);
      chk({tag, "_adr"}, bram_adr, a);
      tick();                                   // e2
      chk({tag, "_en_e2"}, 32'(bram_en), 32'h0);
      chk({tag, "_dsack_e2"}, 32'(DSACKn), 32'h3);
      bram_rdata = d;
      tick();                                   // e3
      bram_rdata = '0;
      chk({tag, "_dsack_e3"}, 32'(DSACKn), 32'h0);
      chk({tag, "_data"}, DATA_IN, d);
      chk({tag, "_we"}, 32'(bram_we), 32'h0);
      chk({tag, "_sdreq"}, 32'(sd_req), 32'h0);
      AS_N = 1'b1;
      tick();                                   // AS_N high sampled
      chk({tag, "_dsack_hold"}, 32'(DSACKn), 32'h0);
      chk({tag, "_data_hold"}, DATA_IN, d);
      tick();
      chk({tag, "_dsack_rel"}, 32'(DSACKn), 32'h3);
   endtask

   initial begin
      // Reset state
      tick(); tick(); tick();
      chk("rst_dsack", 32'(DSACKn), 32'h3);
      chk("rst_berr", 32'(BERRn), 32'h1);
      chk("rst_bram_en", 32'(bram_en), 32'h0);
      chk("rst_bram_we", 32'(bram_we), 32'h0);
      chk("rst_sd_req", 32'(sd_req), 32'h0);
      chk("rst_sd_we", 32'(sd_we), 32'h0);
      chk("rst_sd_be", 32'(sd_be), 32'h0);
      chk("rst_data", DATA_IN, 32'h0);
      chk("rst_adr", bram_adr, 32'h0);
      chk("rst_wdata", sd_wdata, 32'h0);
      RESET_N = 1'b1;
      tick();

      // Block RAM long read
      bram_read("brd", 32'h0000_0100, 32'hDEAD_BEEF);

      // Block RAM word write at offset 1
      AS_N = 1'b0; ADR_OUT = 32'h0000_0201; RWn = 1'b0; SIZE = 2'b10; DATA_OUT = 32'h0012_3400;
      tick();                                   // e0
      tick();                                   // e1
      chk("bwr_en", 32'(bram_en), 32'h1);
      chk("bwr_we", 32'(bram_we), 32'h6);
      chk("bwr_wdata", bram_wdata, 32'h0012_3400);
      chk("bwr_sdreq", 32'(sd_req), 32'h0);
      tick(); tick();                           // e3
      chk("bwr_dsack", 32'(DSACKn), 32'h0);
      chk("bwr_data_kept", DATA_IN, 32'hDEAD_BEEF);
      AS_N = 1'b1;
      tick(); tick();
      chk("bwr_rel", 32'(DSACKn), 32'h3);

      // Block RAM top address, long write at offset 3 -> single lane
      AS_N = 1'b0; ADR_OUT = 32'h0007_FFFF; RWn = 1'b0; SIZE = 2'b00; DATA_OUT = 32'h1122_3344;
      tick(); tick();                           // e1
      chk("btop_en", 32'(bram_en), 32'h1);
      chk("btop_we", 32'(bram_we), 32'h1);
      chk("btop_sdreq", 32'(sd_req), 32'h0);
      tick(); tick();                           // e3
      chk("btop_dsack", 32'(DSACKn), 32'h0);
      AS_N = 1'b1;
      tick(); tick();

      // SDRAM byte read, ack sampled at e6
      AS_N = 1'b0; ADR_OUT = 32'h0010_0003; RWn = 1'b1; SIZE = 2'b01;
      tick(); tick();                           // e1
      chk("sdrd_req_e1", 32'(sd_req), 32'h1);
      chk("sdrd_be", 32'(sd_be), 32'h1);
      chk("sdrd_we", 32'(sd_we), 32'h0);
      chk("sdrd_adr", sd_adr, 32'h0010_0003);
      chk("sdrd_bram_en", 32'(bram_en), 32'h0);
      tick(); tick(); tick(); tick();           // e5
      chk("sdrd_req_e5", 32'(sd_req), 32'h1);
      chk("sdrd_dsack_e5", 32'(DSACKn), 32'h3);
      sd_ack = 1'b1; sd_rdata = 32'h0000_00AB;
      tick();                                   // e6
      sd_ack = 1'b0; sd_rdata = '0;
      chk("sdrd_dsack_e6", 32'(DSACKn), 32'h3);
      tick();                                   // e7
      chk("sdrd_dsack_e7", 32'(DSACKn), 32'h0);
      chk("sdrd_req_e7", 32'(sd_req), 32'h0);
      chk("sdrd_data", DATA_IN, 32'h0000_00AB);
      AS_N = 1'b1;
      tick(); tick();
      chk("sdrd_rel", 32'(DSACKn), 32'h3);

      // SDRAM top address, word at offset 2, ack sampled at e2
      AS_N = 1'b0; ADR_OUT = 32'h03FF_FFFE; RWn = 1'b1; SIZE = 2'b10;
      tick(); tick();                           // e1
      chk("sdtop_req", 32'(sd_req), 32'h1);
      chk("sdtop_be", 32'(sd_be), 32'h3);
      sd_ack = 1'b1; sd_rdata = 32'h5566_7788;
      tick();                                   // e2
      sd_ack = 1'b0; sd_rdata = '0;
      tick();                                   // e3
      chk("sdtop_dsack", 32'(DSACKn), 32'h0);
      chk("sdtop_data", DATA_IN, 32'h5566_7788);
      AS_N = 1'b1;
      tick(); tick();

      // Unmapped address
      AS_N = 1'b0; ADR_OUT = 32'h0400_0000; RWn = 1'b1; SIZE = 2'b00;
      tick();                                   // e0
      chk("umap_berr_e0", 32'(BERRn), 32'h1);
      tick();                                   // e1
      chk("umap_berr_e1", 32'(BERRn), 32'h0);
      chk("umap_bram_en", 32'(bram_en), 32'h0);
      chk("umap_sdreq", 32'(sd_req), 32'h0);
      chk("umap_dsack", 32'(DSACKn), 32'h3);
      AS_N = 1'b1;
      tick();
      chk("umap_berr_hold", 32'(BERRn), 32'h0);
      tick();
      chk("umap_berr_rel", 32'(BERRn), 32'h1);

      // SDRAM timeout: sd_req rises at e1, times out 255 cycles later
      AS_N = 1'b0; ADR_OUT = 32'h0010_0000; RWn = 1'b1; SIZE = 2'b00;
      tick();                                   // e0
      for (int i = 1; i <= 255; i++) tick();    // e255
      chk("to_req_e255", 32'(sd_req), 32'h1);
      tick();                                   // e256
      chk("to_berr_e256", 32'(BERRn), 32'h1);
      tick();                                   // e257
      chk("to_berr_e257", 32'(BERRn), 32'h0);
      chk("to_req_e257", 32'(sd_req), 32'h0);
      AS_N = 1'b1;
      tick(); tick();
      chk("to_rel", 32'(BERRn), 32'h1);

      // SDRAM write aborted two cycles in: drain until ack, no termination
      AS_N = 1'b0; ADR_OUT = 32'h0020_0000; RWn = 1'b0; SIZE = 2'b00; DATA_OUT = 32'hCAFE_F00D;
      tick(); tick();                           // e1
      chk("ab_we", 32'(sd_we), 32'h1);
      chk("ab_be", 32'(sd_be), 32'hF);
      chk("ab_wdata", sd_wdata, 32'hCAFE_F00D);
      tick();                                   // e2
      AS_N = 1'b1;
      tick(); tick(); tick(); tick();           // e6
      chk("ab_req_drain", 32'(sd_req), 32'h1);
      chk("ab_dsack_drain", 32'(DSACKn), 32'h3);
      chk("ab_berr_drain", 32'(BERRn), 32'h1);
      sd_ack = 1'b1;
      tick();                                   // e7
      sd_ack = 1'b0;
      tick();                                   // e8
      chk("ab_req_done", 32'(sd_req), 32'h0);
      chk("ab_dsack_done", 32'(DSACKn), 32'h3);
      bram_read("ab_next", 32'h0000_0010, 32'h0BAD_CAFE);

      // Reset while an SDRAM request is pending
      AS_N = 1'b0; ADR_OUT = 32'h0010_0010; RWn = 1'b1; SIZE = 2'b00;
      tick(); tick(); tick();                   // e2
      chk("mr_req_before", 32'(sd_req), 32'h1);
      RESET_N = 1'b0; AS_N = 1'b1;
      tick();
      chk("mr_req", 32'(sd_req), 32'h0);
      chk("mr_dsack", 32'(DSACKn), 32'h3);
      chk("mr_berr", 32'(BERRn), 32'h1);
      chk("mr_data", DATA_IN, 32'h0);
      RESET_N = 1'b1;
      tick();
      bram_read("mr_next", 32'h0000_0400, 32'h1357_9BDF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
